fft_peak_finder: RTL and testbench
==================================

Name: fft_peak_finder

Overview:
- Avalon-ST consumer on the FFT source port (source_* signals of TunerFFT).
- Accepts one 8192-point complex frame, computes an approximate magnitude per bin and tracks the largest-magnitude bin within a search window.
- Emits the peak bin index and magnitude once per frame for downstream note/cents logic.
- Runs in the CLOCK_50 domain, the same domain as the FFT and the FIFO read side.

Parameters:
- FFT_PTS, 8192: frame length in beats; the bin counter is log2(FFT_PTS) = 13 bits.
- MIN_BIN, 2: lowest bin searched; excludes DC and near-DC bins.
- MAX_BIN, 4095: highest bin searched; positive-frequency half only.
- MIN_MAG, 33'd4096: peak must be at or above this value for peak_found = 1.

Ports:
- CLOCK_50 input 1: system clock.
- reset_n input 1: asynchronous, active-low reset.
- source_valid input 1: FFT output beat valid.
- source_ready output 1: this block ready to accept a beat.
- source_sop input 1: first beat of a frame (bin 0).
- source_eop input 1: last beat of a frame.
- source_error input 2: FFT error code; nonzero marks the frame bad.
- source_real input 32: signed real part.
- source_imag input 32: signed imaginary part.
- peak_bin output 13: index of the peak bin.
- peak_mag output 33: magnitude of the peak bin.
- peak_found output 1: peak_mag >= MIN_MAG.
- result_valid output 1: one-cycle pulse when peak_* update.
- frame_error output 1: sticky error flag; cleared at the next accepted sop.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state = IDLE; all outputs 0 except source_ready.
  - source_ready = 0 while in reset, 1 in IDLE afterwards.
  - Internal counters and the pipeline are cleared.
  - Reset asserted mid-frame aborts the frame with no result_valid.
- Beat acceptance: a beat is accepted when source_valid & source_ready.
- Pipeline:
  - S1 registers |re| and |im|. Abs is computed in 32-bit unsigned, so -2^31 gives 2^31.
  - S2 computes mag = max + (min >> 1), 33-bit unsigned with no overflow, and registers it with its bin index.
  - S3 compares against the running peak and updates when mag > peak.
  - Comparison is strictly greater, so ties keep the lower bin.
  - Only bins in [MIN_BIN, MAX_BIN] are compared.
- State machine:
  - IDLE:
    - Beats without sop are discarded.
    - An accepted sop beat clears the running peak to 0 and peak bin to 0, sets bin counter = 1, processes the beat as bin 0, clears frame_error, and moves to SCAN.
  - SCAN:
    - Each accepted beat increments the bin counter.
    - An accepted sop mid-frame sets frame_error and restarts the frame as bin 0 (stays in SCAN).
    - Accepted eop with counter == FFT_PTS-1 goes to DRAIN.
    - Accepted eop at any other count sets frame_error and goes to IDLE with no result.
    - Counter reaching FFT_PTS-1 without eop on that beat sets frame_error and goes to IDLE.
    - Any accepted beat with source_error != 0 sets frame_error. The frame continues, but no result is produced at eop (goes to IDLE).
  - DRAIN:
    - source_ready = 0 for 3 cycles while S1–S3 flush.
    - On the 3rd cycle, peak_bin, peak_mag and peak_found load, and result_valid pulses 1 cycle later in OUTPUT.
  - OUTPUT: 1 cycle, result_valid = 1, then IDLE.
- Latency: result_valid is asserted exactly 4 CLOCK_50 cycles after the cycle the eop beat is accepted.
- Output holding: peak_* hold their last value until the next successful frame.
- source_ready is 1 in IDLE and SCAN and 0 in DRAIN/OUTPUT. A beat presented during DRAIN is not accepted; the FFT holds it.
- Gaps (source_valid = 0) mid-frame are allowed of any length; the counter holds.

Test Plan:
- Single tone: frame with bin 440 = (re 100000, im 0) and all other bins 0 → result_valid 4 cycles after eop; peak_bin = 440, peak_mag = 100000, peak_found = 1, frame_error = 0.
- Magnitude/abs and window:
  - Bin 3 = (re -2147483648, im -1000) → peak_mag = 2147483648 + 500 = 2147484148.
  - Bin 1 = (re 2^30, im 0) → ignored (below MIN_BIN).
  - Bin 5000 = (re 2^31-1, im 0) → ignored (above MAX_BIN).
- Ties and threshold:
  - Bins 100 and 200 both (re 5000, im 5000) → peak_bin = 100, peak_mag = 7500.
  - All bins (re 10, im 0) → peak_found = 0, peak_mag = 10, peak_bin = 2.
- Framing errors:
  - eop at beat 4000 → frame_error = 1, no result_valid, peak_* unchanged.
  - sop at beat 1000 followed by a full 8192-beat frame → one result_valid; frame_error = 1 until the next clean sop.
- Backpressure/gaps: source_valid toggled at random (50%) across a frame, beat presented during DRAIN → correct peak, source_ready = 0 for exactly 3 cycles after eop, no beat lost.
- Async reset: reset_n pulsed low mid-SCAN at beat 3000 → outputs 0 immediately (without a clock edge), no result_valid; the next full frame produces the correct peak.

Source files
------------

// File: rtl/fft_peak_finder_if.sv
// fft_peak_finder_if: Avalon-ST source bus of the FFT core as seen by the peak finder.
interface fft_peak_finder_if;
  logic        source_valid;
  logic        source_ready;
  logic        source_sop;
  logic        source_eop;
  logic [1:0]  source_error;
  logic [31:0] source_real;
  logic [31:0] source_imag;
  modport master (
    output source_valid, source_sop, source_eop, source_error, source_real, source_imag,
    input  source_ready
  );
  modport slave (
    input  source_valid, source_sop, source_eop, source_error, source_real, source_imag,
    output source_ready
  );
endinterface

// File: rtl/fft_peak_finder.sv
// fft_peak_finder: consumes one FFT frame, tracks the largest approximate-magnitude bin
// inside [MIN_BIN, MAX_BIN] and reports it once per clean frame.
module fft_peak_finder #(
  parameter int          FFT_PTS = 8192,
  parameter int          MIN_BIN = 2,
  parameter int          MAX_BIN = 4095,
  parameter logic [32:0] MIN_MAG = 33'd4096,
  localparam int         BW      = $clog2(FFT_PTS)
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  fft_peak_finder_if.slave src,
  output logic [BW-1:0]    peak_bin,
  output logic [32:0]      peak_mag,
  output logic             peak_found,
  output logic             result_valid,
  output logic             frame_error
);
  localparam logic [BW-1:0] LAST = BW'(FFT_PTS - 1);
  localparam logic [BW-1:0] LO   = BW'(MIN_BIN);
  localparam logic [BW-1:0] HI   = BW'(MAX_BIN);
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_OUTPUT} state_t;
  state_t        r_state, w_next;
  logic [BW-1:0] r_cnt, r_s1_bin, r_s2_bin, r_pk_bin, w_bin;
  logic [1:0]    r_dcnt;
  logic          r_bad, r_s1_v, r_s1_win, r_s2_v;
  logic [31:0]   r_s1_re, r_s1_im, w_mx, w_mn;
  logic [32:0]   r_s2_mag, r_pk_mag;
  logic          w_scan, w_acc, w_sop, w_take, w_err, w_end, w_len_ok, w_good;
  assign w_scan           = r_state == S_SCAN;
  assign src.source_ready = reset_n & ((r_state == S_IDLE) | w_scan);
  assign w_acc            = src.source_valid & src.source_ready;
  assign w_sop            = w_acc & src.source_sop;
  assign w_take           = w_sop | (w_acc & w_scan);
  assign w_err            = w_take & (src.source_error != 2'd0);
  assign w_bin            = src.source_sop ? '0 : r_cnt;
  assign w_end            = w_acc & w_scan & !src.source_sop & (src.source_eop | (r_cnt == LAST));
  assign w_len_ok         = src.source_eop & (r_cnt == LAST);
  assign w_good           = w_len_ok & !r_bad & !w_err;
  assign w_mx             = r_s1_re > r_s1_im ? r_s1_re : r_s1_im;
  assign w_mn             = r_s1_re > r_s1_im ? r_s1_im : r_s1_re;
  assign result_valid     = r_state == S_OUTPUT;
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_sop ? S_SCAN : S_IDLE;
      S_SCAN:  w_next = w_end ? (w_good ? S_DRAIN : S_IDLE) : S_SCAN;
      S_DRAIN: w_next = r_dcnt == 2'd2 ? S_OUTPUT : S_DRAIN;
      default: w_next = S_IDLE;
    endcase
  end
  // r_bad spoils only the current frame; frame_error stays up until a clean sop
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      r_cnt       <= '0;
      r_dcnt      <= 2'd0;
      r_bad       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      r_cnt       <= w_sop ? BW'(1) : r_cnt + BW'(w_take);
      r_dcnt      <= r_state == S_DRAIN ? r_dcnt + 2'd1 : 2'd0;
      r_bad       <= w_sop ? w_err : r_bad | w_err;
      frame_error <= (w_sop & !w_scan) ? w_err
                   : frame_error | w_err | (w_sop & w_scan) | (w_end & !w_len_ok);
    end
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      r_s1_v   <= 1'b0;
      r_s1_win <= 1'b0;
      r_s1_bin <= '0;
      r_s1_re  <= '0;
      r_s1_im  <= '0;
      r_s2_v   <= 1'b0;
      r_s2_mag <= '0;
      r_s2_bin <= '0;
      r_pk_mag <= '0;
      r_pk_bin <= '0;
    end else begin
      r_s1_v   <= w_take;
      r_s1_win <= (w_bin >= LO) && (w_bin <= HI);
      r_s1_bin <= w_bin;
      r_s1_re  <= src.source_real[31] ? -src.source_real : src.source_real;
      r_s1_im  <= src.source_imag[31] ? -src.source_imag : src.source_imag;
      r_s2_v   <= r_s1_v & r_s1_win & !w_sop;
      r_s2_mag <= {1'b0, w_mx} + {2'b0, w_mn[31:1]};
      r_s2_bin <= r_s1_bin;
      if (w_sop) begin
        r_pk_mag <= '0;
        r_pk_bin <= '0;
      end else if (r_s2_v && (r_s2_mag > r_pk_mag)) begin
        r_pk_mag <= r_s2_mag;
        r_pk_bin <= r_s2_bin;
      end
    end
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_found <= 1'b0;
    end else if ((r_state == S_DRAIN) && (r_dcnt == 2'd2)) begin
      peak_bin   <= r_pk_bin;
      peak_mag   <= r_pk_mag;
      peak_found <= r_pk_mag >= MIN_MAG;
    end
endmodule

// File: tb/tb_fft_peak_finder.sv
// tb_fft_peak_finder: directed frame sequence with random data, checked against a
// per-frame peak search done over the whole frame array.
module tb_fft_peak_finder;
  localparam int N = 8192;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [12:0] peak_bin;
  logic [32:0] peak_mag;
  logic        peak_found, result_valid, frame_error;
  int          fre[N], fim[N];
  int          n_chk = 0, n_fail = 0, rv_cnt = 0, rv0, exp_bin = 0;
  longint      exp_mag = 0;
  fft_peak_finder_if bus();
  fft_peak_finder dut (
    .CLOCK_50(clk), .reset_n(reset_n), .src(bus), .peak_bin(peak_bin), .peak_mag(peak_mag),
    .peak_found(peak_found), .result_valid(result_valid), .frame_error(frame_error)
  );
  always #10 clk = ~clk;
  always @(posedge clk) rv_cnt <= rv_cnt + int'(result_valid);
  initial begin
    #3ms;
    $display("FAIL watchdog: observed no finish, expected finish within 3ms");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int rnd(input int span);
    return int'($urandom_range(2 * span)) - span;
  endfunction
  task automatic model();
    exp_bin = 0;
    exp_mag = 0;
    for (int b = 2; b <= 4095; b++) begin
      longint a = fre[b] < 0 ? -longint'(fre[b]) : longint'(fre[b]);
      longint c = fim[b] < 0 ? -longint'(fim[b]) : longint'(fim[b]);
      longint m = (a > c ? a : c) + (a > c ? c : a) / 2;
      if (m > exp_mag) begin
        exp_mag = m;
        exp_bin = b;
      end
    end
  endtask
  task automatic put(input int re, input int im, input bit sop, input bit eop,
                     input logic [1:0] err, input int gap);
    int t = 0;
    while (int'($urandom_range(99)) < gap) begin
      @(negedge clk);
      bus.source_valid = 1'b0;
    end
    @(negedge clk);
    bus.source_valid = 1'b1;
    bus.source_sop   = sop;
    bus.source_eop   = eop;
    bus.source_error = err;
    bus.source_real  = re;
    bus.source_imag  = im;
    while (!bus.source_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) chk("ready_timeout", bus.source_ready, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int first, input int last, input bit eop_last, input int gap,
                      input int err_bin, input logic [1:0] errv);
    for (int b = first; b <= last; b++)
      put(fre[b], fim[b], b == 0, eop_last && b == last, b == err_bin ? errv : 2'd0, gap);
  endtask
  task automatic check_result(input string tag, input bit fe);
    rv0 = rv_cnt;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("%s_ready_c%0d", tag, c), bus.source_ready, c == 5);
      chk($sformatf("%s_rv_c%0d", tag, c), result_valid, c == 4);
      if (c == 4) begin
        chk({tag, "_bin"}, peak_bin, exp_bin);
        chk({tag, "_mag"}, peak_mag, exp_mag);
        chk({tag, "_found"}, peak_found, exp_mag >= 4096);
        chk({tag, "_ferr"}, frame_error, fe);
      end
    end
    chk({tag, "_rv_count"}, rv_cnt, rv0 + 1);
  endtask
  task automatic check_none(input string tag);
    rv0 = rv_cnt;
    repeat (8) @(negedge clk);
    chk({tag, "_no_rv"}, rv_cnt, rv0);
    chk({tag, "_ferr"}, frame_error, 1);
    chk({tag, "_bin_held"}, peak_bin, exp_bin);
    chk({tag, "_mag_held"}, peak_mag, exp_mag);
    chk({tag, "_ready"}, bus.source_ready, 1);
  endtask
  initial begin
    bus.source_valid = 1'b0;
    bus.source_sop   = 1'b0;
    bus.source_eop   = 1'b0;
    bus.source_error = 2'd0;
    bus.source_real  = '0;
    bus.source_imag  = '0;
    #2 reset_n = 1'b0;
    #3;
    chk("rst_ready", bus.source_ready, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_bin", peak_bin, 0);
    chk("rst_mag", peak_mag, 0);
    chk("rst_found", peak_found, 0);
    chk("rst_ferr", frame_error, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1 chk("idle_ready", bus.source_ready, 1);
    // single tone on a silent frame
    for (int b = 0; b < N; b++) begin
      fre[b] = 0;
      fim[b] = 0;
    end
    fre[440] = 100000;
    send(0, N - 1, 1, 0, -1, 2'd0);
    bus.source_valid = 1'b0;
    model();
    check_result("tone", 0);
    // abs corner, window edges and noise, with 50% valid gaps
    for (int b = 0; b < N; b++) begin
      fre[b] = (b < 2 || b > 4095) ? int'($urandom) : rnd(1 << 20);
      fim[b] = (b < 2 || b > 4095) ? int'($urandom) : rnd(1 << 20);
    end
    fre[3]    = int'(32'h8000_0000);
    fim[3]    = -1000;
    fre[1]    = 1 << 30;
    fim[1]    = 0;
    fre[5000] = int'(32'h7fff_ffff);
    fim[5000] = 0;
    send(0, N - 1, 1, 50, -1, 2'd0);
    model();
    for (int b = 0; b < N; b++) begin
      fre[b] = rnd(1000);
      fim[b] = rnd(1000);
    end
    bus.source_sop   = 1'b1;
    bus.source_eop   = 1'b0;
    bus.source_error = 2'd0;
    bus.source_real  = fre[0];
    bus.source_imag  = fim[0];
    check_result("gaps", 0);
    @(posedge clk);
    #1;
    // the held sop beat starts this frame; it ends early at beat 4000
    send(1, 4000, 1, 0, -1, 2'd0);
    bus.source_valid = 1'b0;
    check_none("short_eop");
    send(0, 999, 0, 0, -1, 2'd0);
    for (int b = 0; b < N; b++) begin
      fre[b] = rnd(1000);
      fim[b] = rnd(1000);
    end
    fre[100] = 5000;
    fim[100] = 5000;
    fre[200] = 5000;
    fim[200] = 5000;
    put(fre[0], fim[0], 1, 0, 2'd0, 0);
    chk("midsop_ferr", frame_error, 1);
    send(1, N - 1, 1, 0, -1, 2'd0);
    bus.source_valid = 1'b0;
    model();
    check_result("ties", 1);
    // async reset in the middle of a frame
    for (int b = 0; b < N; b++) begin
      fre[b] = 10;
      fim[b] = 0;
    end
    send(0, 2999, 0, 0, -1, 2'd0);
    bus.source_sop  = 1'b0;
    bus.source_eop  = 1'b0;
    bus.source_real = fre[3000];
    bus.source_imag = fim[3000];
    rv0 = rv_cnt;
    #3 reset_n = 1'b0;
    #1;
    chk("arst_ready", bus.source_ready, 0);
    chk("arst_bin", peak_bin, 0);
    chk("arst_mag", peak_mag, 0);
    chk("arst_found", peak_found, 0);
    chk("arst_ferr", frame_error, 0);
    chk("arst_rv", result_valid, 0);
    @(negedge clk);
    bus.source_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("arst_release_ready", bus.source_ready, 1);
    chk("arst_no_rv", rv_cnt, rv0);
    send(0, N - 1, 1, 0, -1, 2'd0);
    bus.source_valid = 1'b0;
    model();
    check_result("thresh", 0);
    // source_error inside an otherwise complete frame
    for (int b = 0; b < N; b++) begin
      fre[b] = rnd(1 << 20);
      fim[b] = rnd(1 << 20);
    end
    send(0, N - 1, 1, 0, 50, 2'($urandom_range(3, 1)));
    bus.source_valid = 1'b0;
    check_none("err_frame");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
